sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive cycles inst may be refused before it is forced a grant (range 1..15).
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port inst_req, input, 1, instruction read request.
REQ-005 SHALL have port inst_addr, input, 32, instruction byte address.
REQ-006 SHALL have ports inst_gnt (output, 1), inst_rvalid (output, 1) and inst_rdata (output, 32): request accepted, read data valid, read data.
REQ-007 SHALL have ports data_req (input, 1), data_wen (input, 8), data_addr (input, 32) and data_wdata (input, 64): data request, byte write strobes (0 = read), address, write data.
REQ-008 SHALL have port data_lock, input, 1, which holds exclusive SRAM ownership for the data side (AMO read-modify-write).
REQ-009 SHALL have ports data_gnt (output, 1), data_rvalid (output, 1) and data_rdata (output, 64).
REQ-010 SHALL have ports sram_en (output, 1), sram_wen (output, 8), sram_addr (output, 32), sram_wdata (output, 64) and sram_rdata (input, 64): one shared synchronous SRAM with 1-cycle read latency.

Function
REQ-011 SHALL grant at most one requester per cycle, and grant is combinational in the request cycle.
REQ-012 SHALL drive the SRAM from the granted requester only: sram_en=1, sram_addr=that requester's address, and sram_wen=data_wen for data or 0 for inst.
REQ-013 SHALL drive sram_addr=0, sram_wen=0, sram_wdata=0 and sram_en=0 when nothing is granted.
REQ-014 SHALL give data priority over inst when both request, except where REQ-019 and REQ-020 apply.
REQ-015 SHALL register a response tag at each read grant, recording the owner and inst_addr[2].
REQ-016 SHALL assert exactly one of inst_rvalid or data_rvalid in the cycle after a read grant.
REQ-017 SHALL return inst_rdata = sram_rdata[63:32] when the tagged addr[2]=1, and sram_rdata[31:0] otherwise.
REQ-018 SHALL treat data writes (data_wen!=0) as complete at grant, with no data_rvalid; back-to-back grants SHALL sustain 1 access per cycle.
REQ-019 SHALL implement a two-state FSM: ARB and LOCK.
- ARB -> LOCK: a data grant occurs with data_lock=1.
- LOCK -> ARB: data_lock=0.
- In LOCK, inst_gnt=0 and data requests are granted every cycle.
REQ-020 SHALL keep a starvation counter when the SRAM_ARB_STARVE_EN macro is defined (REQ-025).
- In ARB, it increments each cycle inst_req=1 && inst_gnt=0.
- It clears on inst grant or when inst_req=0.
- It saturates at STARVE_MAX.
- At STARVE_MAX, inst wins the next ARB contention.
- It holds in LOCK.
REQ-021 SHALL, when a request drops without a grant, leave no state behind apart from the counter clear.
REQ-022 SHALL ensure the outputs carry no X when reset_n is asserted mid-transaction, and SHALL drop any pending rvalid.

Reset
REQ-023 SHALL, while reset_n=0, force the FSM to ARB, the tag to none, the counter to 0, all rvalid to 0 and all SRAM outputs to 0.
REQ-024 SHALL hold all gnt outputs at 0 while reset_n=0; the first grant is possible in the first cycle after deassertion.

Configuration
REQ-025 SHALL compile the starvation counter and forced inst grant of REQ-020 in only when SRAM_ARB_STARVE_EN is defined.
REQ-026 SHALL use strict data priority when SRAM_ARB_STARVE_EN is undefined, with STARVE_MAX present but unused.

Structure
REQ-027 SHALL place the following in a shared package sram_arb_pkg:
- the owner enum (NONE, INST, DATA);
- the FSM state enum (ARB, LOCK);
- the address width and data width constants (32, 64).
REQ-028 SHALL be a single module with no sub-module; the counter is inline.

Verification
REQ-029 SHALL verify the idle read case: inst_req only, inst_addr=0x80000004 -> inst_gnt the same cycle, sram_addr=0x80000004, next cycle inst_rvalid=1 and inst_rdata=sram_rdata[63:32].
REQ-030 SHALL verify contention: inst_req and data_req read 0x80001000 in the same cycle -> data_gnt=1, inst_gnt=0, data_rvalid next cycle, inst granted the following cycle if data idle.
REQ-031 SHALL verify the lock: data grant with data_lock=1, inst_req held 3 cycles -> inst_gnt=0 throughout LOCK; inst granted the cycle after data_lock=0 when data idle.
REQ-032 SHALL verify starvation with SRAM_ARB_STARVE_EN and STARVE_MAX=4: both requesting continuously -> inst granted on cycle 5, data resumes cycle 6. Without the macro, inst_gnt=0 for all cycles.
REQ-033 SHALL verify writes: data_wen=0xFF, data_wdata=0x1122334455667788 -> sram_wen=0xFF, sram_wdata equal to data_wdata, and data_rvalid=0 next cycle.
REQ-034 SHALL verify reset mid-read: reset_n low in the cycle after a read grant -> no rvalid, all outputs 0, and a normal grant the first cycle after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and constants for the SRAM arbiter: requester
//                owner encoding, arbiter FSM states, bus widths and the
//                response tag carried from a read grant to its data return.
//  Config      : none (consumed by sram_arbiter, which honours
//                SRAM_ARB_STARVE_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;

   // Who owns the read response returning next cycle.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      INST = 2'd1,
      DATA = 2'd2
   } owner_e;

   // ARB: normal arbitration. LOCK: data side holds the SRAM exclusively.
   typedef enum logic [0:0] {
      ARB  = 1'b0,
      LOCK = 1'b1
   } state_e;

   // Response tag; hi selects the upper instruction word of the 64-bit beat.
   typedef struct packed {
      owner_e owner;
      logic   hi;
   } tag_t;

endpackage : sram_arb_pkg

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-requester arbiter in front of one synchronous SRAM with
//                1-cycle read latency. Data has priority over instruction
//                fetch; data_lock gives the data side exclusive ownership for
//                read-modify-write sequences.
//  Config      : `define SRAM_ARB_STARVE_EN adds a saturating starvation
//                counter that forces an instruction grant after STARVE_MAX
//                consecutive refusals. Without it arbitration is strict data
//                priority and STARVE_MAX is unused.
//  Ports       : clock, reset_n             - clock, async active-low reset
//                inst_req/addr -> inst_gnt  - instruction read request/grant
//                inst_rvalid/rdata          - 32-bit instruction return
//                data_req/wen/addr/wdata    - data request (wen=0 is a read)
//                data_lock                  - hold exclusive SRAM ownership
//                data_gnt/rvalid/rdata      - data grant and 64-bit return
//                sram_en/wen/addr/wdata     - shared SRAM command
//                sram_rdata                 - SRAM read data (1 cycle later)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   // instruction port
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [31:0]       inst_rdata,
   // data port
   input  logic              data_req,
   input  logic [STRB_W-1:0] data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   input  logic              data_lock,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   // shared SRAM
   output logic              sram_en,
   output logic [STRB_W-1:0] sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   state_e state_q, state_d;
   tag_t   tag_q, tag_d;
   logic   inst_win;   // starvation forces inst to win a contention

   // -------------------------------------------------------------------------
   // Starvation counter
   // -------------------------------------------------------------------------
`ifdef SRAM_ARB_STARVE_EN
   logic [3:0] starve_q, starve_d;

   assign inst_win = (starve_q == 4'(STARVE_MAX));

   always_comb begin
      starve_d = starve_q;
      if (!inst_req) begin
         starve_d = '0;
      end else if (state_q == LOCK) begin
         starve_d = starve_q;            // refusals under lock do not count
      end else if (inst_gnt) begin
         starve_d = '0;
      end else if (starve_q != 4'(STARVE_MAX)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic unused_starve_cfg;

   assign inst_win          = 1'b0;
   assign unused_starve_cfg = (STARVE_MAX > 0);
`endif

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (data_gnt && data_lock) state_d = LOCK;
         LOCK:    if (!data_lock)            state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs (grants). Gated by reset_n so nothing is granted while the
   // asynchronous reset is held.
   // -------------------------------------------------------------------------
   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (reset_n) begin
         if (state_q == LOCK) begin
            data_gnt = data_req;
         end else if (data_req && !(inst_req && inst_win)) begin
            data_gnt = 1'b1;
         end else if (inst_req) begin
            inst_gnt = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // SRAM command mux: only the granted requester reaches the SRAM
   // -------------------------------------------------------------------------
   always_comb begin
      sram_en    = 1'b0;
      sram_wen   = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (data_gnt) begin
         sram_en    = 1'b1;
         sram_wen   = data_wen;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end else if (inst_gnt) begin
         sram_en    = 1'b1;
         sram_addr  = inst_addr;
      end
   end

   // -------------------------------------------------------------------------
   // Response tag: reads only; writes complete at grant.
   // -------------------------------------------------------------------------
   always_comb begin
      tag_d.owner = NONE;
      tag_d.hi    = 1'b0;
      if (data_gnt && (data_wen == '0)) begin
         tag_d.owner = DATA;
      end else if (inst_gnt) begin
         tag_d.owner = INST;
         tag_d.hi    = inst_addr[2];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tag_q.owner <= NONE;
         tag_q.hi    <= 1'b0;
      end else begin
         tag_q <= tag_d;
      end
   end

   // -------------------------------------------------------------------------
   // Read return. Data buses are zeroed when not valid so an unknown SRAM
   // output never leaks out.
   // -------------------------------------------------------------------------
   assign inst_rvalid = (tag_q.owner == INST);
   assign data_rvalid = (tag_q.owner == DATA);
   assign inst_rdata  = !inst_rvalid ? 32'h0 :
                        tag_q.hi     ? sram_rdata[63:32] : sram_rdata[31:0];
   assign data_rdata  = data_rvalid ? sram_rdata : '0;

endmodule : sram_arbiter

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter: directed scenarios for
//                reset, idle read, contention, lock, starvation, writes and
//                reset during a read, then randomized traffic against a
//                cycle-level reference model of the arbitration rules.
//  Config      : honours SRAM_ARB_STARVE_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

   localparam int STARVE_MAX = 4;
`ifdef SRAM_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        data_req = 1'b0;
   logic [7:0]  data_wen = '0;
   logic [31:0] data_addr = '0;
   logic [63:0] data_wdata = '0;
   logic        data_lock = 1'b0;
   logic [63:0] sram_rdata = '0;

   wire         inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en;
   wire  [31:0] inst_rdata, sram_addr;
   wire  [63:0] data_rdata, sram_wdata;
   wire  [7:0]  sram_wen;

   int n_checks = 0;
   int n_errors = 0;

   sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_gnt   (inst_gnt),
      .inst_rvalid(inst_rvalid),
      .inst_rdata (inst_rdata),
      .data_req   (data_req),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_lock  (data_lock),
      .data_gnt   (data_gnt),
      .data_rvalid(data_rvalid),
      .data_rdata (data_rdata),
      .sram_en    (sram_en),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clock = ~clock;

   // Behavioural SRAM: read data is a fixed function of the address.
   function automatic logic [63:0] mem_fn(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, (~a) + 32'h0000_1357};
   endfunction

   always @(posedge clock) begin
      if (sram_en && sram_wen == 8'h00) sram_rdata <= mem_fn(sram_addr);
   end

   task automatic idle_inputs();
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
      data_lock = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      idle_inputs();
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clock);
      reset_n = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h8000_0004;
      data_req = 1'b1; data_addr = 32'h8000_1000; data_wen = 8'h0F;
      data_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      n_checks++; if (inst_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_inst_gnt: got %b want 0", inst_gnt); end
      n_checks++; if (data_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_data_gnt: got %b want 0", data_gnt); end
      n_checks++; if (sram_en !== 1'b0) begin n_errors++; $display("FAIL reset_sram_en: got %b want 0", sram_en); end
      n_checks++; if (sram_addr !== 32'h0) begin n_errors++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
      n_checks++; if (sram_wen !== 8'h0) begin n_errors++; $display("FAIL reset_sram_wen: got %h want 0", sram_wen); end
      n_checks++; if (sram_wdata !== 64'h0) begin n_errors++; $display("FAIL reset_sram_wdata: got %h want 0", sram_wdata); end
      n_checks++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid: got %b want 00", {inst_rvalid, data_rvalid}); end
      @(negedge clock);
      idle_inputs();
      reset_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_idle_read();
      logic [63:0] m;
      m = mem_fn(32'h8000_0004);
      @(negedge clock);
      inst_req = 1'b1; inst_addr = 32'h8000_0004;
      #1;
      n_checks++; if ({inst_gnt, data_gnt} !== 2'b10) begin n_errors++; $display("FAIL idle_gnt: got %b want 10", {inst_gnt, data_gnt}); end
      n_checks++; if (sram_en !== 1'b1 || sram_addr !== 32'h8000_0004 || sram_wen !== 8'h0) begin n_errors++; $display("FAIL idle_sram: got en=%b addr=%h wen=%h want 1/80000004/00", sram_en, sram_addr, sram_wen); end
      @(negedge clock);
      idle_inputs();
      #1;
      n_checks++; if ({inst_rvalid, data_rvalid} !== 2'b10) begin n_errors++; $display("FAIL idle_rvalid: got %b want 10", {inst_rvalid, data_rvalid}); end
      n_checks++; if (inst_rdata !== m[63:32]) begin n_errors++; $display("FAIL idle_rdata: got %h want %h", inst_rdata, m[63:32]); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_contention();
      logic [63:0] m;
      m = mem_fn(32'h8000_1000);
      @(negedge clock);
      inst_req = 1'b1; inst_addr = 32'h8000_1000;
      data_req = 1'b1; data_addr = 32'h8000_1000; data_wen = 8'h00;
      #1;
      n_checks++; if ({inst_gnt, data_gnt} !== 2'b01) begin n_errors++; $display("FAIL cont_gnt: got %b want 01", {inst_gnt, data_gnt}); end
      n_checks++; if (sram_addr !== 32'h8000_1000) begin n_errors++; $display("FAIL cont_addr: got %h want 80001000", sram_addr); end
      @(negedge clock);
      data_req = 1'b0;
      #1;
      n_checks++; if ({inst_rvalid, data_rvalid} !== 2'b01) begin n_errors++; $display("FAIL cont_drvalid: got %b want 01", {inst_rvalid, data_rvalid}); end
      n_checks++; if (data_rdata !== m) begin n_errors++; $display("FAIL cont_drdata: got %h want %h", data_rdata, m); end
      n_checks++; if (inst_gnt !== 1'b1) begin n_errors++; $display("FAIL cont_inst_next: got %b want 1", inst_gnt); end
      @(negedge clock);
      idle_inputs();
      #1;
      n_checks++; if (inst_rvalid !== 1'b1 || inst_rdata !== m[31:0]) begin n_errors++; $display("FAIL cont_irdata: got v=%b %h want 1 %h", inst_rvalid, inst_rdata, m[31:0]); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_lock();
      @(negedge clock);
      inst_req = 1'b1; inst_addr = 32'h8000_3000;
      data_req = 1'b1; data_addr = 32'h8000_2008; data_lock = 1'b1;
      #1;
      n_checks++; if ({inst_gnt, data_gnt} !== 2'b01) begin n_errors++; $display("FAIL lock_enter: got %b want 01", {inst_gnt, data_gnt}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         data_req = (i == 1); data_addr = 32'h8000_2010;
         #1;
         n_checks++; if ({inst_gnt, data_gnt} !== {1'b0, (i == 1)}) begin n_errors++; $display("FAIL lock_hold%0d: got %b want 0%b", i, {inst_gnt, data_gnt}, (i == 1)); end
      end
      @(negedge clock);
      data_req = 1'b0; data_lock = 1'b0;
      #1;
      n_checks++; if (inst_gnt !== 1'b0) begin n_errors++; $display("FAIL lock_release_cycle: got %b want 0", inst_gnt); end
      @(negedge clock);
      #1;
      n_checks++; if (inst_gnt !== 1'b1) begin n_errors++; $display("FAIL lock_after: got %b want 1", inst_gnt); end
      @(negedge clock);
      idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_starve();
      logic exp_i;
      apply_reset();
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         inst_req = 1'b1; inst_addr = 32'h8000_0100;
         data_req = 1'b1; data_addr = 32'h8000_0200; data_wen = 8'h00;
         #1;
         exp_i = STARVE_EN && (c == 5);
         n_checks++; if ({inst_gnt, data_gnt} !== {exp_i, !exp_i}) begin n_errors++; $display("FAIL starve_c%0d: got %b want %b%b", c, {inst_gnt, data_gnt}, exp_i, !exp_i); end
      end
      @(negedge clock);
      idle_inputs();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_write();
      @(negedge clock);
      data_req = 1'b1; data_addr = 32'h8000_4000; data_wen = 8'hFF;
      data_wdata = 64'h1122_3344_5566_7788;
      #1;
      n_checks++; if (data_gnt !== 1'b1 || sram_en !== 1'b1) begin n_errors++; $display("FAIL wr_gnt: got gnt=%b en=%b want 1/1", data_gnt, sram_en); end
      n_checks++; if (sram_wen !== 8'hFF) begin n_errors++; $display("FAIL wr_wen: got %h want ff", sram_wen); end
      n_checks++; if (sram_wdata !== 64'h1122_3344_5566_7788) begin n_errors++; $display("FAIL wr_wdata: got %h want 1122334455667788", sram_wdata); end
      @(negedge clock);
      idle_inputs();
      #1;
      n_checks++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_errors++; $display("FAIL wr_no_rvalid: got %b want 00", {inst_rvalid, data_rvalid}); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_mid_read();
      logic [63:0] m;
      m = mem_fn(32'h8000_0020);
      @(negedge clock);
      inst_req = 1'b1; inst_addr = 32'h8000_0010;
      #1;
      n_checks++; if (inst_gnt !== 1'b1) begin n_errors++; $display("FAIL rmr_gnt: got %b want 1", inst_gnt); end
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      n_checks++; if ({inst_rvalid, data_rvalid} !== 2'b00) begin n_errors++; $display("FAIL rmr_rvalid: got %b want 00", {inst_rvalid, data_rvalid}); end
      n_checks++; if ({inst_gnt, data_gnt, sram_en} !== 3'b000 || sram_addr !== 32'h0 || inst_rdata !== 32'h0) begin n_errors++; $display("FAIL rmr_outputs: got gnt=%b%b en=%b addr=%h rdata=%h want all 0", inst_gnt, data_gnt, sram_en, sram_addr, inst_rdata); end
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      inst_addr = 32'h8000_0020;
      #1;
      n_checks++; if (inst_gnt !== 1'b1 || sram_addr !== 32'h8000_0020) begin n_errors++; $display("FAIL rmr_first_gnt: got gnt=%b addr=%h want 1/80000020", inst_gnt, sram_addr); end
      @(negedge clock);
      idle_inputs();
      #1;
      n_checks++; if (inst_rvalid !== 1'b1 || inst_rdata !== m[31:0]) begin n_errors++; $display("FAIL rmr_rdata: got v=%b %h want 1 %h", inst_rvalid, inst_rdata, m[31:0]); end
   endtask

   // ------------------------------------------------------------------------
   // Randomized traffic against a rule-level model.
   task automatic test_random();
      bit          locked = 0;
      int          starve = 0;
      bit          exp_ir = 0, exp_dr = 0;
      logic [31:0] exp_irdata = '0;
      logic [63:0] exp_drdata = '0, m;
      bit          eg_i, eg_d;
      logic [31:0] ea;
      logic [7:0]  ew;
      logic [63:0] ewd;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         inst_req   = ($urandom_range(0, 3) != 0);
         inst_addr  = $urandom;
         data_req   = ($urandom_range(0, 1) == 1);
         data_addr  = $urandom;
         data_wen   = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
         data_wdata = {$urandom, $urandom};
         data_lock  = ($urandom_range(0, 3) == 0);
         #1;
         // response from the previous cycle's grant
         n_checks++; if ({inst_rvalid, data_rvalid} !== {exp_ir, exp_dr}) begin n_errors++; $display("FAIL rnd_rvalid[%0d]: got %b want %b%b", n, {inst_rvalid, data_rvalid}, exp_ir, exp_dr); end
         if (exp_ir) begin
            n_checks++; if (inst_rdata !== exp_irdata) begin n_errors++; $display("FAIL rnd_irdata[%0d]: got %h want %h", n, inst_rdata, exp_irdata); end
         end
         if (exp_dr) begin
            n_checks++; if (data_rdata !== exp_drdata) begin n_errors++; $display("FAIL rnd_drdata[%0d]: got %h want %h", n, data_rdata, exp_drdata); end
         end
         // arbitration decision for this cycle
         eg_i = 0; eg_d = 0;
         if (locked) eg_d = data_req;
         else if (data_req && inst_req) begin
            if (STARVE_EN && starve >= STARVE_MAX) eg_i = 1; else eg_d = 1;
         end else begin
            eg_d = data_req; eg_i = inst_req;
         end
         ea  = eg_d ? data_addr : (eg_i ? inst_addr : 32'h0);
         ew  = eg_d ? data_wen : 8'h00;
         ewd = eg_d ? data_wdata : 64'h0;
         n_checks++; if ({inst_gnt, data_gnt} !== {eg_i, eg_d}) begin n_errors++; $display("FAIL rnd_gnt[%0d]: got %b want %b%b", n, {inst_gnt, data_gnt}, eg_i, eg_d); end
         n_checks++; if (sram_en !== (eg_i | eg_d) || sram_addr !== ea || sram_wen !== ew || sram_wdata !== ewd) begin n_errors++; $display("FAIL rnd_sram[%0d]: got en=%b a=%h w=%h d=%h want %b %h %h %h", n, sram_en, sram_addr, sram_wen, sram_wdata, eg_i | eg_d, ea, ew, ewd); end
         // model state update
         m          = mem_fn(inst_addr);
         exp_ir     = eg_i;
         exp_irdata = inst_addr[2] ? m[63:32] : m[31:0];
         exp_dr     = eg_d && (data_wen == 8'h00);
         exp_drdata = mem_fn(data_addr);
         if (!inst_req)   starve = 0;
         else if (locked) starve = starve;
         else if (eg_i)   starve = 0;
         else if (starve < STARVE_MAX) starve = starve + 1;
         locked = locked ? data_lock : (eg_d && data_lock);
      end
      @(negedge clock);
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_idle_read();
      test_contention();
      test_lock();
      test_starve();
      test_write();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_sram_arbiter

`default_nettype wire
